life_grid_engine: RTL and testbench

- Parametrised Conway Game of Life engine. Grid size is set by ROWS x COLS.
- Border mode is selectable: dead border or toroidal wrap.
- The host loads the grid serially with a valid/ready handshake and then runs N generations. The engine stops early if every cell dies.
- The result is streamed out serially with backpressure. The block sits between the board I/O pins and the display logic as the next-generation life core.

---
 rtl/life_grid_engine.sv | 171 +++++++++++++++++
 tb/tb_life_grid_engine.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/life_grid_engine.sv
// Conway Game of Life engine: serial grid load, N-generation run (one row per
// cycle, dead-border or toroidal), early stop on extinction, serial drain.
module life_grid_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic             load_bit,
  output logic             load_ready,
  input  logic             wrap_mode,
  input  logic             start,
  input  logic [GEN_W-1:0] gen_target,
  output logic             busy,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  input  logic             out_ready,
  output logic [GEN_W-1:0] gen_done,
  output logic             extinct,
  output logic [1:0]       state
);
  localparam int N   = ROWS * COLS;
  localparam int IW  = $clog2(N);
  localparam int CW  = $clog2(N + 1);
  localparam int RW  = $clog2(ROWS);
  localparam int CIW = $clog2(COLS);

  typedef enum logic [1:0] {LOAD = 2'b00, RUN = 2'b01, DRAIN = 2'b10} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grid_q, grid_d, next_q, next_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [RW-1:0]    row_q, row_d;
  logic             gv_q, gv_d, wrap_q, wrap_d, ext_q, ext_d;
  logic [GEN_W-1:0] tgt_q, tgt_d, gen_q, gen_d;

  logic [COLS-1:0]  row_new;
  logic [IW-1:0]    row_base, nidx;
  logic [3:0]       nbr;
  logic [31:0]      rr, cc;
  logic             inb, load_hs, start_ok;

  assign load_ready = (state_q == LOAD) && (cnt_q < CW'(N));
  assign load_hs    = load_valid && load_ready;
  assign start_ok   = start && ((cnt_q == CW'(N)) || (cnt_q == '0 && gv_q));
  assign busy       = (state_q == RUN);
  assign out_valid  = (state_q == DRAIN);
  assign out_bit    = out_valid && grid_q[idx_q];
  assign out_last   = out_valid && (idx_q == IW'(N - 1));
  assign gen_done   = gen_q;
  assign extinct    = ext_q;
  assign state      = state_q;
  assign row_base   = IW'(32'(row_q) * COLS);

  // rr/cc are offset by +1 so row/col -1 stays non-negative before the modulo.
  always_comb begin
    row_new = '0;
    nbr     = '0;
    rr      = '0;
    cc      = '0;
    inb     = 1'b0;
    nidx    = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      nbr = '0;
      for (int unsigned dr = 0; dr < 3; dr++) begin
        for (int unsigned dc = 0; dc < 3; dc++) begin
          rr   = 32'(row_q) + dr;
          cc   = c + dc;
          inb  = wrap_q || (rr >= 32'd1 && rr <= ROWS && cc >= 32'd1 && cc <= COLS);
          rr   = (rr + ROWS - 1) % ROWS;
          cc   = (cc + COLS - 1) % COLS;
          nidx = IW'(rr * COLS + cc);
          if (!(dr == 1 && dc == 1) && inb && grid_q[nidx]) nbr = nbr + 4'd1;
        end
      end
      row_new[CIW'(c)] = (nbr == 4'd3) || (grid_q[IW'(32'(row_base) + c)] && nbr == 4'd2);
    end
  end

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    next_d  = next_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    row_d   = row_q;
    gv_d    = gv_q;
    wrap_d  = wrap_q;
    ext_d   = ext_q;
    tgt_d   = tgt_q;
    gen_d   = gen_q;
    unique case (state_q)
      LOAD: begin
        if (load_hs) begin
          grid_d[cnt_q[IW-1:0]] = load_bit;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == '0)         gv_d = 1'b0;
          if (cnt_q == CW'(N - 1)) gv_d = 1'b1;
        end else if (start_ok) begin
          wrap_d  = wrap_mode;
          tgt_d   = gen_target;
          gen_d   = '0;
          ext_d   = 1'b0;
          row_d   = '0;
          idx_d   = '0;
          state_d = (gen_target == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        next_d[row_base +: COLS] = row_new;
        row_d = row_q + RW'(1);
        // next_d already holds the final row, so it is the complete new generation.
        if (row_q == RW'(ROWS - 1)) begin
          grid_d = next_d;
          gen_d  = gen_q + GEN_W'(1);
          ext_d  = (next_d == '0);
          row_d  = '0;
          if (gen_d == tgt_q || next_d == '0) begin
            state_d = DRAIN;
            idx_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(N - 1)) begin
            state_d = LOAD;
            cnt_d   = '0;
            gv_d    = 1'b1;
            idx_d   = '0;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      grid_q  <= '0;
      next_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      gv_q    <= 1'b0;
      wrap_q  <= 1'b0;
      ext_q   <= 1'b0;
      tgt_q   <= '0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      next_q  <= next_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      gv_q    <= gv_d;
      wrap_q  <= wrap_d;
      ext_q   <= ext_d;
      tgt_q   <= tgt_d;
      gen_q   <= gen_d;
    end
  end

endmodule

// File: tb/tb_life_grid_engine.sv
// Self-checking bench for life_grid_engine: array-based Life model plus literal patterns.
module tb_life_grid_engine;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int GEN_W = 8;
  localparam int N     = ROWS * COLS;
  localparam int IW    = $clog2(N);

  logic             clock, reset;
  logic             load_valid, load_bit, load_ready;
  logic             wrap_mode, start;
  logic [GEN_W-1:0] gen_target;
  logic             busy, out_valid, out_bit, out_last, out_ready;
  logic [GEN_W-1:0] gen_done;
  logic             extinct;
  logic [1:0]       state;

  life_grid_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_bit(load_bit), .load_ready(load_ready),
    .wrap_mode(wrap_mode), .start(start), .gen_target(gen_target),
    .busy(busy), .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
    .out_ready(out_ready), .gen_done(gen_done), .extinct(extinct), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int exp_idx = 0;
  int xfers = 0;
  logic mon_en = 1'b0;
  logic [N-1:0] exp_grid = '0;
  logic [N-1:0] got = '0;
  logic [N-1:0] model_grid = '0;
  logic [3:0] bp_pat = 4'b1001;

  // Hand-computed patterns (bit index = r*8+c).
  localparam logic [N-1:0] BLINK_H = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
  localparam logic [N-1:0] BLINK_V = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
  localparam logic [N-1:0] GLIDER  = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 18);
  localparam logic [N-1:0] SINGLE  = (64'd1 << 36);
  localparam logic [N-1:0] BLOCK   = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passes++;
  endtask

  function automatic logic [N-1:0] life_step(input logic [N-1:0] g, input logic w);
    logic [N-1:0] n;
    n = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int live;
        live = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int y, x;
            y = r + dr;
            x = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (w) begin
              y = (y + ROWS) % ROWS;
              x = (x + COLS) % COLS;
            end else if (y < 0 || y >= ROWS || x < 0 || x >= COLS) continue;
            if (g[IW'(y * COLS + x)]) live++;
          end
        end
        n[IW'(r * COLS + c)] = (live == 3) || (g[IW'(r * COLS + c)] && live == 2);
      end
    end
    return n;
  endfunction

  // Output compare: every cycle in which the DUT presents a cell.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      check("valid_only_in_drain", 64'(out_valid), 64'(state == 2'b10));
      if (out_valid) begin
        if (exp_idx < N) begin
          check("out_bit", 64'(out_bit), 64'(exp_grid[exp_idx[IW-1:0]]));
          check("out_last", 64'(out_last), 64'(exp_idx == N - 1));
          if (out_ready) begin
            got[exp_idx[IW-1:0]] = out_bit;
            exp_idx++;
            xfers++;
          end
        end else begin
          check("extra_output", 64'(exp_idx), 64'(N - 1));
        end
      end
    end
  end

  task automatic load_grid(input logic [N-1:0] pat);
    model_grid = pat;
    check("load_ready_empty", 64'(load_ready), 64'd1);
    for (int i = 0; i < N; i++) begin
      load_valid = 1'b1;
      load_bit   = pat[IW'(i)];
      @(posedge clock); #1;
    end
    load_valid = 1'b0;
    check("load_ready_full", 64'(load_ready), 64'd0);
  endtask

  task automatic run_gen(input string nm, input logic w, input logic [GEN_W-1:0] tgt, input logic bp);
    logic [N-1:0] g;
    int done, bc, cyc, k;
    logic ext;
    g = model_grid; done = 0; ext = 1'b0;
    while (done < int'(tgt) && !ext) begin
      g = life_step(g, w);
      done++;
      ext = (g == '0);
    end
    exp_grid = g; exp_idx = 0; xfers = 0; got = '0;
    wrap_mode = w; gen_target = tgt; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    bc = 0; cyc = 0;
    do begin
      @(negedge clock);
      if (busy) bc++;
      cyc++;
    end while (state != 2'b10 && cyc < 3000);
    check({nm, "_reach_drain"}, 64'(state), 64'd2);
    k = 0; cyc = 0;
    do begin
      @(posedge clock); #1;
      out_ready = bp ? bp_pat[k[1:0]] : 1'b1;
      k++; cyc++;
    end while (state != 2'b00 && cyc < 3000);
    out_ready = 1'b1;
    check({nm, "_back_to_load"}, 64'(state), 64'd0);
    check({nm, "_transfers"}, 64'(xfers), 64'(N));
    check({nm, "_grid"}, got, exp_grid);
    check({nm, "_gen_done"}, 64'(gen_done), 64'(done));
    check({nm, "_extinct"}, 64'(extinct), 64'(ext));
    check({nm, "_busy_cycles"}, 64'(bc), 64'(done * ROWS));
    check({nm, "_load_ready"}, 64'(load_ready), 64'd1);
    model_grid = g;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_bit = 1'b0; wrap_mode = 1'b0;
    start = 1'b0; gen_target = '0; out_ready = 1'b1;
    #23;
    check("rst_state", 64'(state), 64'd0);
    check("rst_load_ready", 64'(load_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bit", 64'(out_bit), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_gen_done", 64'(gen_done), 64'd0);
    check("rst_extinct", 64'(extinct), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clock); #1;

    load_grid(BLINK_H);
    run_gen("blink1", 1'b0, 8'd1, 1'b0);
    check("blink1_literal", got, BLINK_V);

    load_grid(BLINK_H);
    run_gen("blink2", 1'b0, 8'd2, 1'b0);
    check("blink2_literal", got, BLINK_H);
    run_gen("blink_retained", 1'b0, 8'd1, 1'b0);
    check("blink_retained_literal", got, BLINK_V);

    load_grid(GLIDER);
    run_gen("glider_wrap", 1'b1, 8'd32, 1'b0);
    check("glider_literal", got, GLIDER);
    check("glider_gen_literal", 64'(gen_done), 64'd32);

    load_grid(SINGLE);
    run_gen("single", 1'b0, 8'd5, 1'b0);
    check("single_literal", got, 64'd0);
    check("single_gen_literal", 64'(gen_done), 64'd1);
    check("single_extinct_literal", 64'(extinct), 64'd1);

    load_grid(BLOCK);
    run_gen("block", 1'b0, 8'd10, 1'b0);
    check("block_literal", got, BLOCK);
    check("block_gen_literal", 64'(gen_done), 64'd10);

    run_gen("block_backpressure", 1'b0, 8'd1, 1'b1);
    check("bp_literal", got, BLOCK);

    load_grid(GLIDER);
    run_gen("target_zero", 1'b0, 8'd0, 1'b0);
    check("target_zero_literal", got, GLIDER);

    // Abort in row 3 of the third generation.
    load_grid(BLINK_H);
    wrap_mode = 1'b0; gen_target = 8'd20; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2 * ROWS + 3) @(posedge clock);
    #2;
    check("pre_abort_busy", 64'(busy), 64'd1);
    check("pre_abort_gen_done", 64'(gen_done), 64'd2);
    reset = 1'b1;
    #1;
    check("abort_state", 64'(state), 64'd0);
    check("abort_load_ready", 64'(load_ready), 64'd1);
    check("abort_gen_done", 64'(gen_done), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("start_ignored_state", 64'(state), 64'd0);
      check("start_ignored_busy", 64'(busy), 64'd0);
    end
    start = 1'b0;
    @(posedge clock); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
